// File: rtl/dds_seq_ctrl_if.sv
// Config word stream into dds_seq_ctrl: valid/ready handshake carrying the word
// and an end-of-load marker.
interface dds_seq_ctrl_if #(
  parameter int SIG_WIDTH = 16
);
  logic                 i_cfg_valid;
  logic                 o_cfg_ready;
  logic [SIG_WIDTH-1:0] i_cfg_data;
  logic                 i_cfg_last;

  modport master (output i_cfg_valid, i_cfg_data, i_cfg_last, input o_cfg_ready);
  modport slave  (input i_cfg_valid, i_cfg_data, i_cfg_last, output o_cfg_ready);
endinterface

// File: rtl/dds_seq_ctrl.sv
// DDS sequencer: clears the DDS, loads theta/delta/ampl shift registers from a config
// stream, then rotates channels while running. End-of-load framing check: DDS_SEQ_CTRL_LAST_CHECK_EN.
module dds_seq_ctrl #(
  parameter int         SIG_WIDTH = 16,
  parameter int         NUM_CH    = 8,
  parameter logic [8:0] THETAS    = 9'd0,
  parameter logic [8:0] DELTAS    = 9'd1,
  parameter logic [8:0] AMPLS     = 9'd2,
  parameter logic [8:0] IDLE_ADDR = 9'h1FF
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 i_load_req,
  input  logic                 i_run,
  dds_seq_ctrl_if.slave        cfg,
  output logic                 o_dds_rst,
  output logic                 o_dds_start,
  output logic [8:0]           o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                 o_busy,
  output logic                 o_running,
  output logic [15:0]          o_rot_cnt,
  output logic                 o_err
);

  localparam int            CW      = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE, CLR, LD_THETA, LD_DELTA, LD_AMPL, ARMED, RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] ch_cnt;
  logic [CW-1:0] rot_pos;
  logic          hs;
  logic          last_bad;

  assign hs = cfg.i_cfg_valid & cfg.o_cfg_ready;

`ifdef DDS_SEQ_CTRL_LAST_CHECK_EN
  // The marker must be set on the last ampl word and on no other accepted word.
  assign last_bad = cfg.i_cfg_last != ((state == LD_AMPL) && (ch_cnt == LAST_CH));
`else
  logic unused_last;
  assign unused_last = cfg.i_cfg_last;
  assign last_bad    = 1'b0;
`endif

  function automatic logic [8:0] ld_addr(input state_t s);
    case (s)
      LD_THETA: ld_addr = THETAS;
      LD_DELTA: ld_addr = DELTAS;
      LD_AMPL:  ld_addr = AMPLS;
      default:  ld_addr = IDLE_ADDR;
    endcase
  endfunction

  function automatic state_t ld_next(input state_t s);
    case (s)
      LD_THETA: ld_next = LD_DELTA;
      LD_DELTA: ld_next = LD_AMPL;
      LD_AMPL:  ld_next = ARMED;
      default:  ld_next = IDLE;
    endcase
  endfunction

  // Sequencer state, rotation tracking and all registered outputs.
  always_ff @(posedge clk) begin
    if (!a_rst_n) begin
      state           <= IDLE;
      ch_cnt          <= {CW{1'b0}};
      rot_pos         <= {CW{1'b0}};
      o_rot_cnt       <= 16'd0;
      o_dds_rst       <= 1'b0;
      o_dds_start     <= 1'b0;
      o_dds_addrs     <= IDLE_ADDR;
      o_dds_fifo_data <= {SIG_WIDTH{1'b0}};
      cfg.o_cfg_ready <= 1'b0;
      o_busy          <= 1'b0;
      o_running       <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_dds_rst       <= 1'b0;
      o_dds_addrs     <= IDLE_ADDR;
      o_dds_fifo_data <= {SIG_WIDTH{1'b0}};

      // Every cycle with start high shifts the DDS by one channel.
      if (o_dds_start) begin
        if (rot_pos == LAST_CH) begin
          rot_pos   <= {CW{1'b0}};
          o_rot_cnt <= o_rot_cnt + 16'd1;
        end else begin
          rot_pos <= rot_pos + CW'(1);
        end
      end

      if (i_load_req) begin
        state           <= CLR;
        ch_cnt          <= {CW{1'b0}};
        o_dds_rst       <= 1'b1;
        o_dds_start     <= 1'b0;
        cfg.o_cfg_ready <= 1'b0;
        o_busy          <= 1'b1;
        o_running       <= 1'b0;
        o_err           <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          CLR: begin
            state           <= LD_THETA;
            cfg.o_cfg_ready <= 1'b1;
          end
          LD_THETA, LD_DELTA, LD_AMPL: begin
            if (hs && last_bad) begin
              state           <= IDLE;
              cfg.o_cfg_ready <= 1'b0;
              o_busy          <= 1'b0;
              o_err           <= 1'b1;
            end else if (hs) begin
              o_dds_addrs     <= ld_addr(state);
              o_dds_fifo_data <= cfg.i_cfg_data;
              if (ch_cnt == LAST_CH) begin
                ch_cnt <= {CW{1'b0}};
                state  <= ld_next(state);
                if (state == LD_AMPL) begin
                  cfg.o_cfg_ready <= 1'b0;
                  o_busy          <= 1'b0;
                end
              end else begin
                ch_cnt <= ch_cnt + CW'(1);
              end
            end
          end
          ARMED: begin
            if (i_run) begin
              state       <= RUN;
              o_dds_start <= 1'b1;
              o_running   <= 1'b1;
            end
          end
          RUN: begin
            if (!i_run) begin
              state       <= ARMED;
              o_dds_start <= 1'b0;
              o_running   <= 1'b0;
            end
          end
          default: begin
            state           <= IDLE;
            o_dds_start     <= 1'b0;
            cfg.o_cfg_ready <= 1'b0;
            o_busy          <= 1'b0;
            o_running       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Directed bench for dds_seq_ctrl with NUM_CH=4: load, gapped load, run, abort,
// load-over-run and end-of-load marker handling.
module tb_dds_seq_ctrl;

  localparam int         W    = 16;
  localparam logic [8:0] IDLE = 9'h1FF;

  logic        clk = 1'b0;
  logic        a_rst_n, i_load_req, i_run;
  logic        o_dds_rst, o_dds_start, o_busy, o_running, o_err;
  logic [8:0]  o_dds_addrs;
  logic [W-1:0] o_dds_fifo_data;
  logic [15:0] o_rot_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  dds_seq_ctrl_if #(.SIG_WIDTH(W)) cfg ();

  dds_seq_ctrl #(.SIG_WIDTH(W), .NUM_CH(4)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .i_load_req(i_load_req), .i_run(i_run), .cfg(cfg),
    .o_dds_rst(o_dds_rst), .o_dds_start(o_dds_start), .o_dds_addrs(o_dds_addrs),
    .o_dds_fifo_data(o_dds_fifo_data), .o_busy(o_busy), .o_running(o_running),
    .o_rot_cnt(o_rot_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full configuration load; gaps toggles valid, bad marks a word with a wrong last flag.
  task automatic load_seq(input bit gaps, input int bad);
    i_load_req = 1'b1;
    tick();
    chk("clr_rst", o_dds_rst, 1);
    chk("clr_busy", o_busy, 1);
    chk("clr_ready", cfg.o_cfg_ready, 0);
    i_load_req = 1'b0;
    tick();
    chk("ld_rst_low", o_dds_rst, 0);
    chk("ld_ready", cfg.o_cfg_ready, 1);
    for (int k = 1; k <= 12; k++) begin
      cfg.i_cfg_valid = 1'b1;
      cfg.i_cfg_data  = W'(k);
      cfg.i_cfg_last  = (k == 12) || (k == bad);
      tick();
`ifdef DDS_SEQ_CTRL_LAST_CHECK_EN
      if (k == bad) begin
        cfg.i_cfg_valid = 1'b0;
        cfg.i_cfg_last  = 1'b0;
        chk("bad_err", o_err, 1);
        chk("bad_ready", cfg.o_cfg_ready, 0);
        chk("bad_addr", o_dds_addrs, IDLE);
        chk("bad_busy", o_busy, 0);
        return;
      end
`endif
      chk("ld_addr", o_dds_addrs, (k - 1) / 4);
      chk("ld_data", o_dds_fifo_data, k);
      if (gaps) begin
        cfg.i_cfg_valid = 1'b0;
        cfg.i_cfg_last  = 1'b0;
        tick();
        chk("gap_addr", o_dds_addrs, IDLE);
        chk("gap_data", o_dds_fifo_data, 0);
      end
    end
    cfg.i_cfg_valid = 1'b0;
    cfg.i_cfg_last  = 1'b0;
    chk("armed_ready", cfg.o_cfg_ready, 0);
    chk("armed_busy", o_busy, 0);
    chk("armed_running", o_running, 0);
    chk("armed_err", o_err, 0);
    tick();
    chk("armed_addr", o_dds_addrs, IDLE);
    chk("armed_start", o_dds_start, 0);
  endtask

  initial begin
    a_rst_n = 1'b0; i_load_req = 1'b0; i_run = 1'b0;
    cfg.i_cfg_valid = 1'b0; cfg.i_cfg_data = '0; cfg.i_cfg_last = 1'b0;
    tick(); tick();
    chk("rst_rst", o_dds_rst, 0);
    chk("rst_start", o_dds_start, 0);
    chk("rst_addr", o_dds_addrs, IDLE);
    chk("rst_data", o_dds_fifo_data, 0);
    chk("rst_ready", cfg.o_cfg_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_running", o_running, 0);
    chk("rst_rot", o_rot_cnt, 0);
    chk("rst_err", o_err, 0);
    a_rst_n = 1'b1;

    // Idle ignores run.
    i_run = 1'b1;
    tick(); tick();
    chk("idle_start", o_dds_start, 0);
    i_run = 1'b0;

    load_seq(1'b0, 0);
    load_seq(1'b1, 0);

    // Run 10 cycles: two full rotations after 8 run cycles.
    i_run = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("run_start", o_dds_start, 1);
      chk("run_running", o_running, 1);
      chk("run_rot", o_rot_cnt, (c - 1) / 4);
    end
    i_run = 1'b0;
    tick();
    chk("stop_start", o_dds_start, 0);
    chk("stop_rot", o_rot_cnt, 2);
    tick(); tick();
    chk("hold_rot", o_rot_cnt, 2);

    // Abort mid delta load after two delta words.
    i_load_req = 1'b1; tick(); i_load_req = 1'b0; tick();
    for (int k = 1; k <= 6; k++) begin
      cfg.i_cfg_valid = 1'b1; cfg.i_cfg_data = W'(k); cfg.i_cfg_last = 1'b0;
      tick();
    end
    chk("pre_abort_addr", o_dds_addrs, 1);
    i_load_req = 1'b1; cfg.i_cfg_data = W'(7);
    tick();
    chk("abort_rst", o_dds_rst, 1);
    chk("abort_addr", o_dds_addrs, IDLE);
    chk("abort_ready", cfg.o_cfg_ready, 0);
    i_load_req = 1'b0; cfg.i_cfg_data = W'(16'h0055);
    tick();
    chk("abort_rst_low", o_dds_rst, 0);
    tick();
    chk("reload_addr", o_dds_addrs, 0);
    chk("reload_data", o_dds_fifo_data, 16'h0055);
    cfg.i_cfg_valid = 1'b0;
    load_seq(1'b0, 0);

    // Load request beats run while running.
    i_run = 1'b1; tick(); tick();
    chk("run2_start", o_dds_start, 1);
    i_load_req = 1'b1;
    tick();
    chk("lr_run_start", o_dds_start, 0);
    chk("lr_run_running", o_running, 0);
    chk("lr_run_rst", o_dds_rst, 1);
    chk("lr_run_busy", o_busy, 1);
    i_load_req = 1'b0; i_run = 1'b0;
    tick();

    // Wrong last flag on word 7.
    load_seq(1'b0, 7);
`ifdef DDS_SEQ_CTRL_LAST_CHECK_EN
    cfg.i_cfg_valid = 1'b1;
    i_run = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("err_no_start", o_dds_start, 0);
      chk("err_no_load", o_dds_addrs, IDLE);
      chk("err_sticky", o_err, 1);
    end
    cfg.i_cfg_valid = 1'b0;
    i_run = 1'b0;
`endif

    // Reset during a load.
    i_load_req = 1'b1; tick(); i_load_req = 1'b0; tick();
    cfg.i_cfg_valid = 1'b1; cfg.i_cfg_data = W'(16'h00AA);
    tick();
    a_rst_n = 1'b0;
    tick();
    chk("mid_rst_ready", cfg.o_cfg_ready, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_addr", o_dds_addrs, IDLE);
    a_rst_n = 1'b1; cfg.i_cfg_valid = 1'b0;
    tick();
    chk("mid_rst_idle", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
